// File: rtl/dmadd_seq_if.sv
// dmadd_seq_if: bundles the upstream beat handshake and the downstream
// multiply-add stage signals of dmadd_seq.
// slave  : the sequencer's view.
// master : the view of whatever drives beats and consumes the results.
// Build option: DMADD_SEQ_ABORT_EN adds the abort input.
interface dmadd_seq_if;
    // Upstream beat handshake
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [1:0]  insn_cfg;

    // Downstream multiply-add stage
    logic [3:0]  index;
    logic [3:0]  data;
    logic [1:0]  insn;
    logic        load;
    logic        run;
    logic [11:0] res_in;
    logic [11:0] result;
    logic        result_valid;
    logic        busy;

`ifdef DMADD_SEQ_ABORT_EN
    logic        abort;

    modport slave (
        input  in_valid, in_data, in_last, insn_cfg, res_in, abort,
        output in_ready, index, data, insn, load, run, result, result_valid, busy
    );

    modport master (
        output in_valid, in_data, in_last, insn_cfg, res_in, abort,
        input  in_ready, index, data, insn, load, run, result, result_valid, busy
    );
`else
    modport slave (
        input  in_valid, in_data, in_last, insn_cfg, res_in,
        output in_ready, index, data, insn, load, run, result, result_valid, busy
    );

    modport master (
        output in_valid, in_data, in_last, insn_cfg, res_in,
        input  in_ready, index, data, insn, load, run, result, result_valid, busy
    );
`endif
endinterface

// File: rtl/dmadd_seq.sv
// dmadd_seq: sequencer for a multiply-add stage.
// Accepts a set of beats {index, data} into a 4-entry FIFO, replays them
// one per cycle as load strobes, then holds run for RUN_CYCLES cycles and
// captures the downstream result with a one-cycle result_valid pulse.
// Build option: DMADD_SEQ_ABORT_EN adds an abort input that abandons a set
// in LOAD or RUN (FIFO flushed, no result).
module dmadd_seq #(
    parameter int unsigned RUN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    dmadd_seq_if.slave bus
);

    localparam int unsigned Depth   = 4;
    localparam logic [4:0]  RunLast = 5'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;

    // FIFO entry layout: {index[3:0], data[3:0], last}
    logic [8:0]  fifo_q [Depth];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic [8:0]  head;
    logic        full, empty;
    logic        push, pop, flush;

    logic        last_acc_q;
    logic        load_q, load_last_q;
    logic [3:0]  index_q, data_q;
    logic [1:0]  insn_q;
    logic [11:0] result_q;

    logic        in_ready;
    logic        run;
    logic        busy;
    logic        result_valid;
    logic        run_done;
    logic        abort_hit;

`ifdef DMADD_SEQ_ABORT_EN
    assign abort_hit = bus.abort && ((state_q == StLoad) || (state_q == StRun));
`else
    assign abort_hit = 1'b0;
`endif

    assign full  = (count_q == 3'(Depth));
    assign empty = (count_q == 3'd0);
    assign head  = fifo_q[rd_ptr_q];
    assign flush = abort_hit;

    // Once the last beat of a set is in, nothing more is taken until IDLE.
    assign in_ready = rst_n && !full && !last_acc_q &&
                      ((state_q == StIdle) || (state_q == StLoad));
    assign push     = bus.in_valid && in_ready;
    assign pop      = (state_q == StLoad) && !empty && !abort_hit;

    // Next-state, run counter and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run          = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        run_done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (push) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort_hit) begin
                    state_d = StIdle;
                end else if (load_q && load_last_q) begin
                    // The last entry's load strobe is on the outputs now.
                    state_d = StRun;
                end
            end
            StRun: begin
                run = 1'b1;
                if (abort_hit) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else if (cnt_q == RunLast) begin
                    state_d  = StDone;
                    cnt_d    = 5'd0;
                    run_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                result_valid = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and run-cycle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Beat FIFO: simultaneous push and pop leave the occupancy unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                fifo_q[i] <= 9'd0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else if (flush) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {bus.in_data, bus.in_last};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Remember that the set's last beat was accepted; cleared on the way back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_acc_q <= 1'b0;
        end else if (abort_hit || (state_q == StDone)) begin
            last_acc_q <= 1'b0;
        end else if (push && bus.in_last) begin
            last_acc_q <= 1'b1;
        end
    end

    // Registered load strobe and payload: one popped entry per cycle, payload holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q      <= 1'b0;
            load_last_q <= 1'b0;
            index_q     <= 4'd0;
            data_q      <= 4'd0;
        end else begin
            load_q      <= pop;
            load_last_q <= pop && head[0];
            if (pop) begin
                index_q <= head[8:5];
                data_q  <= head[4:1];
            end
        end
    end

    // Opcode is taken from the first accepted beat of a set only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_q <= 2'd0;
        end else if ((state_q == StIdle) && push) begin
            insn_q <= bus.insn_cfg;
        end
    end

    // Capture the downstream result at the end of the final run cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 12'd0;
        end else if (run_done) begin
            result_q <= bus.res_in;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.index        = index_q;
    assign bus.data         = data_q;
    assign bus.insn         = insn_q;
    assign bus.load         = load_q;
    assign bus.run          = run;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid;
    assign bus.busy         = busy;

endmodule

// File: tb/tb_dmadd_seq.sv
// tb_dmadd_seq: randomized self-checking bench for dmadd_seq.
// The reference is the set itself: every accepted set must come back as the
// same beats in order as load strobes, followed by RUN_CYCLES consecutive run
// cycles and exactly one result_valid pulse on the following cycle.
module tb_dmadd_seq;

    localparam int unsigned RunCycles = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dmadd_seq_if bus ();
    dmadd_seq_if bus1 ();

    dmadd_seq #(.RUN_CYCLES(RunCycles)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dmadd_seq #(.RUN_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation of the downstream side, sampled mid-cycle
    int          cyc = 0;
    logic [7:0]  got_q[$];
    logic [1:0]  got_insn;
    int          run_cnt, rv_cnt, overlap_cnt;
    int          first_run_cyc, last_run_cyc, last_load_cyc, rv_cyc;
    logic [11:0] rv_result;

    always @(negedge clk) begin
        cyc++;
        if (bus.load) begin
            got_q.push_back({bus.index, bus.data});
            got_insn      = bus.insn;
            last_load_cyc = cyc;
        end
        if (bus.run) begin
            if (run_cnt == 0) first_run_cyc = cyc;
            run_cnt++;
            last_run_cyc = cyc;
        end
        if (bus.result_valid) begin
            rv_cnt++;
            rv_cyc    = cyc;
            rv_result = bus.result;
        end
        if (bus.load && bus.run) overlap_cnt++;
    end

    task automatic mon_clear();
        got_q.delete();
        got_insn      = 2'd0;
        run_cnt       = 0;
        rv_cnt        = 0;
        overlap_cnt   = 0;
        first_run_cyc = -1;
        last_run_cyc  = -1;
        last_load_cyc = -1;
        rv_cyc        = -1;
        rv_result     = 12'd0;
    endtask

    logic [7:0]  stim_q[$];
    logic [11:0] model_result = 12'd0;

    // Present every beat of stim_q, holding each until accepted
    task automatic send_beats(input logic [1:0] cfg, input int max_gap);
        int gap;
        int waitc;
        bit acc;
        foreach (stim_q[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            bus.in_valid = 1'b0;
            for (int k = 0; k < gap; k++) begin
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[i];
            bus.in_last  = (i == stim_q.size() - 1);
            // Opcode on later beats is noise and must not be latched
            bus.insn_cfg = (i == 0) ? cfg : 2'($urandom);
            waitc = 0;
            do begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                waitc++;
            end while (!acc && waitc < 100);
            if (!acc) check_eq("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic run_set(input logic [1:0] cfg, input logic [11:0] res, input int max_gap,
                           input bit hold_after);
        int waitc;
        int ready_seen;
        mon_clear();
        bus.res_in = res;
        send_beats(cfg, max_gap);
        if (hold_after) begin
            // Keep offering a beat that must not be taken before IDLE
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hEE;
            bus.in_last  = 1'($urandom);
            bus.insn_cfg = ~cfg;
        end else begin
            bus.in_valid = 1'b0;
        end
        waitc      = 0;
        ready_seen = 0;
        while (rv_cnt == 0 && waitc < 200) begin
            @(negedge clk);
            if (bus.in_ready) ready_seen++;
            @(posedge clk);
            #1;
            waitc++;
        end
        if (hold_after) begin
            check_eq("post_last_ready", 32'(ready_seen), 32'd0);
            @(negedge clk);
            check_eq("idle_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("load_count", 32'(got_q.size()), 32'(stim_q.size()));
        foreach (stim_q[i]) begin
            check_eq("load_data", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD,
                     32'(stim_q[i]));
        end
        check_eq("insn", 32'(got_insn), 32'(cfg));
        check_eq("run_count", 32'(run_cnt), 32'(RunCycles));
        check_eq("run_contig", 32'(last_run_cyc - first_run_cyc + 1), 32'(RunCycles));
        check_eq("run_after_load", 32'(first_run_cyc), 32'(last_load_cyc + 1));
        check_eq("rv_count", 32'(rv_cnt), 32'd1);
        check_eq("rv_timing", 32'(rv_cyc), 32'(last_run_cyc + 1));
        check_eq("result", 32'(rv_result), 32'(res));
        check_eq("result_hold", 32'(bus.result), 32'(res));
        check_eq("load_run_excl", 32'(overlap_cnt), 32'd0);
        model_result = res;
    endtask

    initial begin
        int w;
        int run_at_reset;
        bit acc;
        int loads1, runs1, rvs1, run_c1, rv_c1;
        logic [11:0] r1;
        logic [1:0]  insn1;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.insn_cfg  = 2'd0;
        bus.res_in    = 12'd0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = 8'h00;
        bus1.in_last  = 1'b0;
        bus1.insn_cfg = 2'd0;
        bus1.res_in   = 12'd0;
`ifdef DMADD_SEQ_ABORT_EN
        bus.abort     = 1'b0;
        bus1.abort    = 1'b0;
`endif
        mon_clear();

        // Reset state
        #3;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_outputs", 32'({bus.index, bus.data, bus.insn, bus.load, bus.run,
                 bus.result_valid, bus.busy}), 32'd0);
        check_eq("rst_result", 32'(bus.result), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        // Basic three-beat set
        stim_q = '{8'h31, 8'h52, 8'h7F};
        run_set(2'd2, 12'h9C3, 0, 1'b0);

        // Six beats back-to-back
        stim_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        run_set(2'd1, 12'h123, 0, 1'b0);

        // Single-beat set
        stim_q = '{8'h00};
        run_set(2'd3, 12'hFA5, 0, 1'b0);

        // Randomized sets; some keep in_valid high past the last beat
        for (int s = 0; s < 8; s++) begin
            int len;
            len = int'($urandom_range(6, 1));
            stim_q.delete();
            for (int b = 0; b < len; b++) stim_q.push_back(8'($urandom));
            run_set(2'($urandom), 12'($urandom), 2, (s % 3) == 1);
        end

`ifdef DMADD_SEQ_ABORT_EN
        // Abort on the fifth run cycle
        mon_clear();
        bus.res_in = 12'h777;
        stim_q = '{8'hA1, 8'hB2};
        send_beats(2'd1, 0);
        bus.in_valid = 1'b0;
        w = 0;
        while (run_cnt < 4 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check_eq("abort_run", 32'(bus.run), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_load", 32'(bus.load), 32'd0);
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check_eq("abort_run_count", 32'(run_cnt), 32'd5);
        check_eq("abort_no_rv", 32'(rv_cnt), 32'd0);
        check_eq("abort_result", 32'(bus.result), 32'(model_result));
        stim_q = '{8'h4C, 8'h5D};
        run_set(2'd0, 12'h0F0, 1, 1'b0);
`endif

        // Reset in the middle of RUN
        mon_clear();
        bus.res_in = 12'hBAD;
        stim_q = '{8'h12, 8'h34};
        send_beats(2'd2, 0);
        bus.in_valid = 1'b0;
        w = 0;
        while (run_cnt < 3 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        run_at_reset = run_cnt;
        check_eq("mid_rst_run", 32'(bus.run), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_result", 32'(bus.result), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        check_eq("mid_rst_rv", 32'(bus.result_valid), 32'd0);
        #10;
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_rst_no_rv", 32'(rv_cnt), 32'd0);
        check_eq("mid_rst_no_run", 32'(run_cnt), 32'(run_at_reset));

        // RUN_CYCLES = 1 instance, single beat 0x00 with last
        bus1.res_in   = 12'h5A5;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'h00;
        bus1.in_last  = 1'b1;
        bus1.insn_cfg = 2'd1;
        w = 0;
        do begin
            @(negedge clk);
            acc = bus1.in_ready;
            @(posedge clk);
            #1;
            w++;
        end while (!acc && w < 50);
        bus1.in_valid = 1'b0;
        check_eq("rc1_accept", 32'(acc), 32'd1);
        loads1 = 0;
        runs1  = 0;
        rvs1   = 0;
        run_c1 = -1;
        rv_c1  = -1;
        r1     = 12'd0;
        insn1  = 2'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus1.load) begin
                loads1++;
                insn1 = bus1.insn;
            end
            if (bus1.run) begin
                runs1++;
                run_c1 = c;
            end
            if (bus1.result_valid) begin
                rvs1++;
                rv_c1 = c;
                r1    = bus1.result;
            end
            @(posedge clk);
            #1;
        end
        check_eq("rc1_loads", 32'(loads1), 32'd1);
        check_eq("rc1_runs", 32'(runs1), 32'd1);
        check_eq("rc1_rvs", 32'(rvs1), 32'd1);
        check_eq("rc1_rv_timing", 32'(rv_c1), 32'(run_c1 + 1));
        check_eq("rc1_result", 32'(r1), 32'h5A5);
        check_eq("rc1_insn", 32'(insn1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
